// File: rtl/regfile_wb_queue_pkg.sv
// Shared types for the register-file write-back queue.
// Not clocked and has no handshake of its own.
package regfile_wb_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Producer handshakes, register-file write port, forwarding lookups and status of the write-back queue.
// Not clocked; the producer-side ready signals are driven by the queue.
interface regfile_wb_queue_if
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4
);

    logic                    ld_valid;
    logic                    ld_ready;
    logic [AW-1:0]           ld_rd;
    logic [XLEN-1:0]         ld_data;
    logic                    alu_valid;
    logic                    alu_ready;
    logic [AW-1:0]           alu_rd;
    logic [XLEN-1:0]         alu_data;
    logic                    wb_hold;
    logic                    rf_we;
    logic [AW-1:0]           rf_waddr;
    logic [XLEN-1:0]         rf_wdata;
    logic [AW-1:0]           rs1;
    logic [AW-1:0]           rs2;
    logic                    rs1_fwd_valid;
    logic [XLEN-1:0]         rs1_fwd_data;
    logic                    rs2_fwd_valid;
    logic [XLEN-1:0]         rs2_fwd_data;
    logic [$clog2(DEPTH):0]  count;
    logic                    full;
    logic                    empty;

    modport master (
        output ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, wb_hold, rs1, rs2,
        input  ld_ready, alu_ready, rf_we, rf_waddr, rf_wdata,
        input  rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data, count, full, empty
    );

    modport slave (
        input  ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, wb_hold, rs1, rs2,
        output ld_ready, alu_ready, rf_we, rf_waddr, rf_wdata,
        output rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data, count, full, empty
    );

endinterface

// File: rtl/regfile_wb_queue_fwd_match.sv
// Youngest-match lookup of a register index across the queued write-back entries.
// Purely combinational (zero latency); it has no handshake and never stalls.
module wb_fwd_match
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t                  ent_i [DEPTH],
    input  logic [DEPTH-1:0]           vld_i,
    input  logic [$clog2(DEPTH)-1:0]   head_i,
    input  logic [AW-1:0]              rs_i,
    output logic                       fwd_vld_o,
    output logic [XLEN-1:0]            fwd_dat_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk oldest to youngest so the last hit is the youngest one.
    always_comb begin
        fwd_vld_o = 1'b0;
        fwd_dat_o = '0;
        idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PW'(k);
            if (rs_i != '0 && vld_i[idx] && ent_i[idx].rd == rs_i) begin
                fwd_vld_o = 1'b1;
                fwd_dat_o = ent_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue feeding the register file write port, with load-over-ALU priority and read forwarding.
// Accept-to-write latency is at least one edge after enqueue; readies drop while full and wb_hold stalls draining.
module regfile_wb_queue
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    regfile_wb_queue_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t        ent_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic       full, empty;
    logic       ld_hs, alu_hs, push, pop;
    wb_entry_t  push_ent, head_ent;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // No pass-through: a pop in the same cycle does not open a slot.
    assign bus.ld_ready  = !reset && !full;
    assign bus.alu_ready = !reset && !full && !bus.ld_valid;

    assign ld_hs  = bus.ld_valid  && bus.ld_ready;
    assign alu_hs = bus.alu_valid && bus.alu_ready;

    always_comb begin
        push_ent = '0;
        if (ld_hs) begin
            push_ent.rd   = bus.ld_rd;
            push_ent.data = bus.ld_data;
        end else begin
            push_ent.rd   = bus.alu_rd;
            push_ent.data = bus.alu_data;
        end
    end

    // x0 writes complete their handshake but are dropped here.
    assign push = (ld_hs || alu_hs) && (push_ent.rd != '0);
    assign pop  = !empty && !bus.wb_hold;

    assign head_ent     = ent_q[head_q];
    assign bus.rf_we    = pop;
    assign bus.rf_waddr = pop ? head_ent.rd   : '0;
    assign bus.rf_wdata = pop ? head_ent.data : '0;

    assign bus.count = count_q;
    assign bus.full  = full;
    assign bus.empty = empty;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        vld_d   = vld_q;
        count_d = count_q + CW'(push) - CW'(pop);
        if (push) begin
            tail_d        = tail_q + 1'b1;
            vld_d[tail_q] = 1'b1;
        end
        if (pop) begin
            head_d        = head_q + 1'b1;
            vld_d[head_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            vld_q   <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            vld_q   <= vld_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: the valid bits qualify every use.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_q[tail_q] <= push_ent;
        end
    end

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_rs1 (
        .ent_i     (ent_q),
        .vld_i     (vld_q),
        .head_i    (head_q),
        .rs_i      (bus.rs1),
        .fwd_vld_o (bus.rs1_fwd_valid),
        .fwd_dat_o (bus.rs1_fwd_data)
    );

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_rs2 (
        .ent_i     (ent_q),
        .vld_i     (vld_q),
        .head_i    (head_q),
        .rs_i      (bus.rs2),
        .fwd_vld_o (bus.rs2_fwd_valid),
        .fwd_dat_o (bus.rs2_fwd_data)
    );

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: a queue-based reference model checked every cycle, plus directed literal checks.
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } m_t;

    logic clk = 1'b0;
    logic reset;

    regfile_wb_queue_if #(.DEPTH(DEPTH)) bus ();

    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    m_t  mq[$];
    m_t  dut_log[$];
    m_t  acc[$];
    bit  wrap_on = 1'b0;
    int  max_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [32:0] mfwd(input logic [4:0] rs);
        if (rs != 5'd0)
            for (int i = mq.size() - 1; i >= 0; i--)
                if (mq[i].rd == rs) return {1'b1, mq[i].data};
        return 33'd0;
    endfunction

    // Reference: a plain FIFO of accepted non-x0 writes.
    bit m_full, m_ldhs, m_aluhs, m_pop;
    m_t m_new;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
        end else begin
            m_full  = (mq.size() == DEPTH);
            m_pop   = (mq.size() > 0) && !bus.wb_hold;
            m_ldhs  = bus.ld_valid && !m_full;
            m_aluhs = bus.alu_valid && !m_full && !bus.ld_valid;
            m_new.rd   = m_ldhs ? bus.ld_rd   : bus.alu_rd;
            m_new.data = m_ldhs ? bus.ld_data : bus.alu_data;
            if (m_pop) void'(mq.pop_front());
            if ((m_ldhs || m_aluhs) && m_new.rd != 5'd0) mq.push_back(m_new);
        end
    end

    logic [32:0] e1, e2;
    bit          e_we;
    m_t          obs;
    always @(negedge clk) begin
        e_we = (mq.size() > 0) && !bus.wb_hold;
        e1   = mfwd(bus.rs1);
        e2   = mfwd(bus.rs2);
        chk("ld_ready",  bus.ld_ready,  !reset && mq.size() < DEPTH);
        chk("alu_ready", bus.alu_ready, !reset && mq.size() < DEPTH && !bus.ld_valid);
        chk("rf_we",     bus.rf_we,     e_we);
        chk("rf_waddr",  bus.rf_waddr,  e_we ? mq[0].rd   : 5'd0);
        chk("rf_wdata",  bus.rf_wdata,  e_we ? mq[0].data : 32'd0);
        chk("count",     bus.count,     mq.size());
        chk("full",      bus.full,      mq.size() == DEPTH);
        chk("empty",     bus.empty,     mq.size() == 0);
        chk("fwd1_v",    bus.rs1_fwd_valid, e1[32]);
        chk("fwd1_d",    bus.rs1_fwd_data,  e1[31:0]);
        chk("fwd2_v",    bus.rs2_fwd_valid, e2[32]);
        chk("fwd2_d",    bus.rs2_fwd_data,  e2[31:0]);
        if (bus.rf_we === 1'b1) begin
            obs.rd   = bus.rf_waddr;
            obs.data = bus.rf_wdata;
            dut_log.push_back(obs);
        end
        if (wrap_on && int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.ld_valid = 0; bus.ld_rd = 0; bus.ld_data = 0;
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.wb_hold = 0; bus.rs1 = 0; bus.rs2 = 0;
        step(); step();
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full",  bus.full, 0);
        chk("rst_ldrdy", bus.ld_ready, 0);
        chk("rst_alurdy", bus.alu_ready, 0);
        chk("rst_we",    bus.rf_we, 0);
        reset = 1'b0;
        step();

        // Single write
        bus.ld_valid = 1; bus.ld_rd = 5; bus.ld_data = 32'hDEAD_BEEF; bus.rs1 = 5;
        #1 chk("t1_ldrdy", bus.ld_ready, 1);
        step();
        bus.ld_valid = 0;
        #1;
        chk("t1_we", bus.rf_we, 1);
        chk("t1_waddr", bus.rf_waddr, 5);
        chk("t1_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
        chk("t1_fwdv", bus.rs1_fwd_valid, 1);
        chk("t1_fwdd", bus.rs1_fwd_data, 32'hDEAD_BEEF);
        step();
        chk("t1_empty", bus.empty, 1);
        chk("t1_fwdv0", bus.rs1_fwd_valid, 0);

        // Priority
        bus.ld_valid = 1; bus.ld_rd = 3; bus.ld_data = 1;
        bus.alu_valid = 1; bus.alu_rd = 4; bus.alu_data = 2;
        #1;
        chk("t2_ldrdy", bus.ld_ready, 1);
        chk("t2_alurdy", bus.alu_ready, 0);
        step();
        bus.ld_valid = 0;
        #1;
        chk("t2_alurdy1", bus.alu_ready, 1);
        chk("t2_waddr3", bus.rf_waddr, 3);
        chk("t2_wdata1", bus.rf_wdata, 1);
        step();
        bus.alu_valid = 0;
        #1;
        chk("t2_waddr4", bus.rf_waddr, 4);
        chk("t2_wdata2", bus.rf_wdata, 2);
        step();
        chk("t2_empty", bus.empty, 1);

        // Fill and stall
        bus.wb_hold = 1;
        for (int i = 1; i <= 4; i++) begin
            bus.alu_valid = 1; bus.alu_rd = 5'(i); bus.alu_data = 32'h100 + i;
            step();
        end
        bus.alu_rd = 9; bus.ld_valid = 1; bus.ld_rd = 9;
        #1;
        chk("t3_full", bus.full, 1);
        chk("t3_count", bus.count, 4);
        chk("t3_ldrdy", bus.ld_ready, 0);
        chk("t3_alurdy", bus.alu_ready, 0);
        chk("t3_hold_we", bus.rf_we, 0);
        step();
        bus.ld_valid = 0; bus.alu_valid = 0; bus.wb_hold = 0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("t3_we", bus.rf_we, 1);
            chk("t3_waddr", bus.rf_waddr, i);
            chk("t3_wdata", bus.rf_wdata, 32'h100 + i);
            step();
        end
        chk("t3_empty", bus.empty, 1);
        chk("t3_we0", bus.rf_we, 0);

        // Youngest forward
        bus.wb_hold = 1;
        bus.ld_valid = 1; bus.ld_rd = 7; bus.ld_data = 10;
        step();
        bus.ld_data = 20;
        step();
        bus.ld_valid = 0; bus.rs2 = 7;
        #1;
        chk("t4_fwdv", bus.rs2_fwd_valid, 1);
        chk("t4_fwdd", bus.rs2_fwd_data, 20);
        bus.wb_hold = 0;
        step();
        chk("t4_fwdd1", bus.rs2_fwd_data, 20);
        chk("t4_count1", bus.count, 1);
        step();
        chk("t4_fwdv0", bus.rs2_fwd_valid, 0);

        // x0 and reset
        bus.ld_valid = 1; bus.ld_rd = 0; bus.ld_data = 32'hFF; bus.rs1 = 0;
        #1 chk("t5_ldrdy", bus.ld_ready, 1);
        step();
        bus.ld_valid = 0;
        #1;
        chk("t5_count0", bus.count, 0);
        chk("t5_we0", bus.rf_we, 0);
        chk("t5_fwdv0", bus.rs1_fwd_valid, 0);
        bus.wb_hold = 1;
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1; bus.alu_rd = 5'(10 + i); bus.alu_data = 32'hA0 + i;
            step();
        end
        bus.alu_valid = 0; bus.rs1 = 10;
        #1;
        chk("t5_count3", bus.count, 3);
        chk("t5_fwd10", bus.rs1_fwd_data, 32'hA0);
        reset = 1; bus.wb_hold = 0;
        #1;
        chk("t5_rst_we", bus.rf_we, 0);
        chk("t5_rst_waddr", bus.rf_waddr, 0);
        chk("t5_rst_count", bus.count, 0);
        chk("t5_rst_empty", bus.empty, 1);
        chk("t5_rst_rdy", bus.ld_ready, 0);
        chk("t5_rst_fwdv", bus.rs1_fwd_valid, 0);
        chk("t5_rst_fwdd", bus.rs1_fwd_data, 0);
        step(); step();
        reset = 0;
        step();
        chk("t5_post_we", bus.rf_we, 0);
        chk("t5_post_empty", bus.empty, 1);

        // Wrap
        dut_log.delete(); acc.delete(); max_cnt = 0; wrap_on = 1;
        for (int i = 0; i < 10; i++) begin
            m_t a;
            a.rd = 5'($urandom_range(1, 31));
            a.data = $urandom;
            bus.ld_valid = 1; bus.ld_rd = a.rd; bus.ld_data = a.data;
            acc.push_back(a);
            step();
        end
        bus.ld_valid = 0;
        step(); step();
        wrap_on = 0;
        chk("t6_len", dut_log.size(), 10);
        for (int i = 0; i < 10 && i < dut_log.size(); i++) begin
            chk("t6_rd", dut_log[i].rd, acc[i].rd);
            chk("t6_data", dut_log[i].data, acc[i].data);
        end
        chk("t6_maxcnt", max_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
